edc_pipe: RTL and testbench
===========================

# edc_pipe

Pipelined, parametrised SEC-DED encode/check unit for the memory data path. Each 32-bit lane carries an 8-bit check byte. In generate mode the block produces check bytes for write data. In check mode it computes syndromes, corrects single-bit data errors and flags uncorrectable ones. A two-stage valid/ready pipeline sits between the memory controller and main memory, with optional saturating error counters for status registers.

## Interface
- `LANES`, default 1: number of 32-bit lanes; data width is 32·LANES and check width is 8·LANES.
- `TAG_W`, default 4: width of the sideband tag carried through alongside each beat.
- `CNT_W`, default 16: width of each error counter.

- `i_clk` in 1: single clock.
- `i_rst_n` in 1: reset, synchronous and active-low.
- `i_valid` in 1: input beat valid.
- `o_ready` out 1: block can accept an input beat.
- `i_we` in 1: 1 = generate (write), 0 = check (read).
- `i_data` in 32·LANES: data.
- `i_check` in 8·LANES: stored check bytes; ignored when `i_we`=1.
- `i_tag` in TAG_W: sideband tag.
- `o_valid` out 1: output beat valid.
- `i_ready` in 1: downstream accepts the output beat.
- `o_data` out 32·LANES: data (corrected in check mode).
- `o_check` out 8·LANES: check bytes of `o_data`.
- `o_syndrome` out 8·LANES: per-lane syndrome; 0 in generate mode.
- `o_ce` out LANES: per-lane corrected-error flag.
- `o_ue` out LANES: per-lane uncorrectable-error flag.
- `o_tag` out TAG_W: tag, delayed to match its beat.
- `i_cnt_clr` in 1: clear both counters.
- `o_ce_cnt` out CNT_W: count of beats with any CE.
- `o_ue_cnt` out CNT_W: count of beats with any UE.

## Operation
- Check-bit equations, per lane with d = lane data: c[k] = XOR(d & M[k]).
  - M7=0x8888FF00, M6=0x444400FF, M5=0x2222F0F0, M4=0x11110F0F.
  - M3=0xFF008888, M2=0x00FF4444, M1=0xF0F02222, M0=0x0F0F1111.
- The column of data bit i is the 8-bit vector {M7[i]..M0[i]}. Each column has weight 3 and all columns are distinct. Examples: bit0 = 0x51, bit31 = 0x8A.
- Generate mode (`i_we`=1):
  - `o_data` = `i_data`; `o_check` = generated check bytes.
  - Syndrome, `o_ce` and `o_ue` are all 0.
- Check mode (`i_we`=0): per lane, s = gen(d) ^ `i_check`, and the lane is classified as follows.
  - s=0: no error.
  - s equals column of bit i: flip d[i]; ce=1.
  - s has weight 1: error is in a check bit; data is unchanged; ce=1.
  - Any other s: data is passed unchanged; ue=1; ce=0.
- In check mode, `o_check` = gen(`o_data`).
- Lanes are independent. One lane may be CE while another is UE in the same beat.
- Counters, updated on each output handshake (`o_valid`&`i_ready`):
  - `o_ce_cnt` increments by 1 if any `o_ce` bit is set; `o_ue_cnt` increments by 1 if any `o_ue` bit is set. Both may increment in the same cycle.
  - Each counter saturates at 2^CNT_W−1.
  - `i_cnt_clr` takes priority over an increment in the same cycle.

## Timing
- Stage 1 registers the inputs and the syndrome. Stage 2 registers corrected data, check bytes, flags and tag.
- Latency is 2 cycles from input handshake to `o_valid` when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake and flow control:
  - s1 advances when `~s2_v | i_ready`.
  - `o_ready` = `~s1_v | s1_advance`, purely combinational from `i_ready` and state.
  - Input is accepted on `i_valid`&`o_ready`; output is transferred on `o_valid`&`i_ready`.
  - While `o_valid` is high and `i_ready` is low, all outputs hold stable.
- Reset (`i_rst_n`=0 at a clock edge):
  - Both valid bits clear; `o_valid`=0.
  - All data, check, syndrome, flag and tag outputs are 0; counters are 0.
  - Any in-flight beats are discarded. `o_ready`=1 in the first cycle after reset deasserts.
- Counter outputs are registered and update the cycle after the handshake.

## Configuration
- `EDC_ERR_CNT_EN` defined: the counters and `i_cnt_clr` behave as specified above.
- Undefined: no counter flops are built; `o_ce_cnt` and `o_ue_cnt` are tied to 0 and `i_cnt_clr` is ignored. Pipeline behaviour is otherwise identical.

## Structure
- Package `edc_pkg` holds:
  - the eight masks M0..M7;
  - constants for lane width (32) and check width (8);
  - a function returning the column of bit i.
- Sub-module `edc_lane` is combinational and instantiated LANES times. It computes gen, syndrome, corrected data, ce and ue for one lane. Pipeline registers and counters live in `edc_pipe`.

## Test plan
- Generate, LANES=1: `i_data`=0x00000001 → `o_check`=0x51. `i_data`=0x80000000 → `o_check`=0x8A. `i_data`=0 → 0x00. Output arrives 2 cycles after handshake.
- Single data-bit error: check mode, `i_data`=0x00000000, `i_check`=0x51 → `o_data`=0x00000001, `o_syndrome`=0x51, ce=1, ue=0.
- Check-bit error: `i_data`=0, `i_check`=0x04 → `o_data`=0, `o_syndrome`=0x04, ce=1.
- Double error: `i_data`=0x80000001, `i_check`=0x00 → syndrome 0xDB, ue=1, data unchanged. With `EDC_ERR_CNT_EN`, `o_ue_cnt` goes 0→1.
- LANES=2, lane0 CE and lane1 UE in one beat → `o_ce`=01, `o_ue`=10, and both counters +1. `i_cnt_clr` together with a new error → counters read 0.
- Backpressure: hold `i_ready`=0 for 5 cycles during a stream of 4 beats → exactly 2 beats are held with outputs stable and `o_ready` low. All 4 beats emerge in order with matching tags. Asserting `i_rst_n`=0 mid-stream clears `o_valid` the next cycle.

Source files
------------

// File: rtl/edc_pkg.sv
// SEC-DED code definition shared by the lane datapath and the pipeline.
// Holds the eight check-bit masks, the lane/check widths and helpers
// returning a data bit's H-matrix column and a lane's check byte.
package edc_pkg;

  localparam int EDC_LANE_W = 32;
  localparam int EDC_CHK_W  = 8;

  // Check bit k is the parity of the lane data under mask Mk.
  localparam logic [31:0] EDC_M7 = 32'h8888FF00;
  localparam logic [31:0] EDC_M6 = 32'h444400FF;
  localparam logic [31:0] EDC_M5 = 32'h2222F0F0;
  localparam logic [31:0] EDC_M4 = 32'h11110F0F;
  localparam logic [31:0] EDC_M3 = 32'hFF008888;
  localparam logic [31:0] EDC_M2 = 32'h00FF4444;
  localparam logic [31:0] EDC_M1 = 32'hF0F02222;
  localparam logic [31:0] EDC_M0 = 32'h0F0F1111;

  function automatic logic [31:0] edc_mask(input logic [2:0] k);
    logic [31:0] m;
    case (k)
      3'd7:    m = EDC_M7;
      3'd6:    m = EDC_M6;
      3'd5:    m = EDC_M5;
      3'd4:    m = EDC_M4;
      3'd3:    m = EDC_M3;
      3'd2:    m = EDC_M2;
      3'd1:    m = EDC_M1;
      default: m = EDC_M0;
    endcase
    return m;
  endfunction

  // Syndrome produced by a single flip of data bit i (weight-3, unique).
  function automatic logic [7:0] edc_col(input logic [4:0] i);
    return {EDC_M7[i], EDC_M6[i], EDC_M5[i], EDC_M4[i],
            EDC_M3[i], EDC_M2[i], EDC_M1[i], EDC_M0[i]};
  endfunction

  function automatic logic [7:0] edc_gen(input logic [31:0] d);
    logic [7:0] g;
    g = '0;
    for (int k = 0; k < 8; k++) begin
      g[k] = ^(d & edc_mask(3'(k)));
    end
    return g;
  endfunction

endpackage

// File: rtl/edc_lane.sv
// One 32-bit lane of SEC-DED logic, purely combinational.
// Input side: syndrome of the raw beat (forced to 0 when generating).
// Registered side: correction, flags and check byte from the stage-1 syndrome.
module edc_lane
  import edc_pkg::*;
(
  input  logic [31:0] in_data_i,
  input  logic [7:0]  in_check_i,
  input  logic        in_we_i,
  output logic [7:0]  in_syn_o,
  input  logic [31:0] s1_data_i,
  input  logic [7:0]  s1_syn_i,
  output logic [31:0] cor_data_o,
  output logic [7:0]  cor_check_o,
  output logic        ce_o,
  output logic        ue_o
);

  logic [31:0] flip;
  logic        data_err;
  logic        chk_err;

  // Syndrome of the incoming beat; generate beats carry a zero syndrome so
  // the correction stage passes them through untouched.
  always_comb begin
    in_syn_o = '0;
    if (!in_we_i) begin
      in_syn_o = edc_gen(in_data_i) ^ in_check_i;
    end
  end

  // Decode the registered syndrome: data-column match flips that bit,
  // weight-1 means a check-bit error, anything else non-zero is uncorrectable.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 32; i++) begin
      flip[i] = (s1_syn_i == edc_col(5'(i)));
    end
    data_err   = |flip;
    chk_err    = $onehot(s1_syn_i);
    cor_data_o = s1_data_i ^ flip;
    ce_o       = data_err | chk_err;
    ue_o       = (s1_syn_i != 8'h00) & ~(data_err | chk_err);
  end

  assign cor_check_o = edc_gen(cor_data_o);

endmodule

// File: rtl/edc_pipe.sv
// Two-stage SEC-DED generate/check pipeline with optional error counters
// (EDC_ERR_CNT_EN builds the counters). Latency 2 cycles, 1 beat/cycle.
// Backpressure: o_ready drops only when both stages are full and i_ready is low.
module edc_pipe
  import edc_pkg::*;
#(
  parameter int LANES = 1,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_we,
  input  logic [EDC_LANE_W*LANES-1:0] i_data,
  input  logic [EDC_CHK_W*LANES-1:0]  i_check,
  input  logic [TAG_W-1:0]            i_tag,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [EDC_LANE_W*LANES-1:0] o_data,
  output logic [EDC_CHK_W*LANES-1:0]  o_check,
  output logic [EDC_CHK_W*LANES-1:0]  o_syndrome,
  output logic [LANES-1:0]            o_ce,
  output logic [LANES-1:0]            o_ue,
  output logic [TAG_W-1:0]            o_tag,
  input  logic                        i_cnt_clr,
  output logic [CNT_W-1:0]            o_ce_cnt,
  output logic [CNT_W-1:0]            o_ue_cnt
);

  localparam int DW = EDC_LANE_W * LANES;
  localparam int CW = EDC_CHK_W * LANES;

  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s1_adv, in_hs, s1_load;

  logic [DW-1:0]    s1_data_q;
  logic [CW-1:0]    s1_syn_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic [DW-1:0]    s2_data_q;
  logic [CW-1:0]    s2_check_q;
  logic [CW-1:0]    s2_syn_q;
  logic [LANES-1:0] s2_ce_q;
  logic [LANES-1:0] s2_ue_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic [CW-1:0]    in_syn;
  logic [DW-1:0]    cor_data;
  logic [CW-1:0]    cor_check;
  logic [LANES-1:0] cor_ce;
  logic [LANES-1:0] cor_ue;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    edc_lane u_lane (
      .in_data_i   (i_data[g*EDC_LANE_W +: EDC_LANE_W]),
      .in_check_i  (i_check[g*EDC_CHK_W +: EDC_CHK_W]),
      .in_we_i     (i_we),
      .in_syn_o    (in_syn[g*EDC_CHK_W +: EDC_CHK_W]),
      .s1_data_i   (s1_data_q[g*EDC_LANE_W +: EDC_LANE_W]),
      .s1_syn_i    (s1_syn_q[g*EDC_CHK_W +: EDC_CHK_W]),
      .cor_data_o  (cor_data[g*EDC_LANE_W +: EDC_LANE_W]),
      .cor_check_o (cor_check[g*EDC_CHK_W +: EDC_CHK_W]),
      .ce_o        (cor_ce[g]),
      .ue_o        (cor_ue[g])
    );
  end

  assign s1_adv  = ~s2_v_q | i_ready;
  assign o_ready = ~s1_v_q | s1_adv;
  assign in_hs   = i_valid & o_ready;
  assign s1_load = s1_v_q & s1_adv;

  // Valid-bit next state: a stage refills (or empties) whenever it may advance.
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (o_ready) s1_v_d = i_valid;
    if (s1_adv)  s2_v_d = s1_v_q;
  end

  // Stage 1: capture the accepted beat and its raw syndrome.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
      s1_tag_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      if (in_hs) begin
        s1_data_q <= i_data;
        s1_syn_q  <= in_syn;
        s1_tag_q  <= i_tag;
      end
    end
  end

  // Stage 2: capture corrected data, regenerated check bytes and flags; held while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_v_q     <= 1'b0;
      s2_data_q  <= '0;
      s2_check_q <= '0;
      s2_syn_q   <= '0;
      s2_ce_q    <= '0;
      s2_ue_q    <= '0;
      s2_tag_q   <= '0;
    end else begin
      s2_v_q <= s2_v_d;
      if (s1_load) begin
        s2_data_q  <= cor_data;
        s2_check_q <= cor_check;
        s2_syn_q   <= s1_syn_q;
        s2_ce_q    <= cor_ce;
        s2_ue_q    <= cor_ue;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  assign o_valid    = s2_v_q;
  assign o_data     = s2_data_q;
  assign o_check    = s2_check_q;
  assign o_syndrome = s2_syn_q;
  assign o_ce       = s2_ce_q;
  assign o_ue       = s2_ue_q;
  assign o_tag      = s2_tag_q;

`ifdef EDC_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_hs;
  logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;
  logic [CNT_W-1:0] ue_cnt_q, ue_cnt_d;

  assign out_hs = s2_v_q & i_ready;

  // Saturating per-beat error counts; a clear wins over a same-cycle increment.
  always_comb begin
    ce_cnt_d = ce_cnt_q;
    ue_cnt_d = ue_cnt_q;
    if (i_cnt_clr) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else if (out_hs) begin
      if ((|s2_ce_q) && (ce_cnt_q != CNT_MAX)) ce_cnt_d = ce_cnt_q + 1'b1;
      if ((|s2_ue_q) && (ue_cnt_q != CNT_MAX)) ue_cnt_d = ue_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else begin
      ce_cnt_q <= ce_cnt_d;
      ue_cnt_q <= ue_cnt_d;
    end
  end

  assign o_ce_cnt = ce_cnt_q;
  assign o_ue_cnt = ue_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;
  assign o_ce_cnt       = '0;
  assign o_ue_cnt       = '0;
`endif

endmodule

// File: tb/tb_edc_pipe.sv
// Directed bench for edc_pipe: one LANES=1 and one LANES=2 instance.
// Expected values are hand-derived from the mask table.
// Counter expectations follow whether EDC_ERR_CNT_EN is defined.
module tb_edc_pipe;

`ifdef EDC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // LANES=1 instance
  logic        v1, we1, rdy1, clr1;
  logic [31:0] d1;
  logic [7:0]  c1;
  logic [3:0]  t1;
  logic        o_ready1, o_valid1;
  logic [31:0] od1;
  logic [7:0]  oc1, os1;
  logic [0:0]  oce1, oue1;
  logic [3:0]  ot1;
  logic [15:0] cec1, uec1;

  // LANES=2 instance
  logic        v2, we2, rdy2, clr2;
  logic [63:0] d2;
  logic [15:0] c2;
  logic [3:0]  t2;
  logic        o_ready2, o_valid2;
  logic [63:0] od2;
  logic [15:0] oc2, os2;
  logic [1:0]  oce2, oue2;
  logic [3:0]  ot2;
  logic [15:0] cec2, uec2;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ce = '0;
  logic [15:0] exp_ue = '0;

  edc_pipe #(.LANES(1), .TAG_W(4), .CNT_W(16)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(o_ready1), .i_we(we1),
    .i_data(d1), .i_check(c1), .i_tag(t1), .o_valid(o_valid1), .i_ready(rdy1),
    .o_data(od1), .o_check(oc1), .o_syndrome(os1), .o_ce(oce1), .o_ue(oue1),
    .o_tag(ot1), .i_cnt_clr(clr1), .o_ce_cnt(cec1), .o_ue_cnt(uec1)
  );

  edc_pipe #(.LANES(2), .TAG_W(4), .CNT_W(16)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(o_ready2), .i_we(we2),
    .i_data(d2), .i_check(c2), .i_tag(t2), .o_valid(o_valid2), .i_ready(rdy2),
    .o_data(od2), .o_check(oc2), .o_syndrome(os2), .o_ce(oce2), .o_ue(oue2),
    .o_tag(ot2), .i_cnt_clr(clr2), .o_ce_cnt(cec2), .o_ue_cnt(uec2)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Present one beat to the LANES=1 instance for exactly one accepting edge.
  task automatic beat1(input logic we, input logic [31:0] d, input logic [7:0] c,
                       input logic [3:0] t);
    v1 = 1'b1; we1 = we; d1 = d; c1 = c; t1 = t;
    next();
    v1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    next();
    next();
    checks++; if (o_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid1); end
    checks++; if (od1 !== 32'h0 || oc1 !== 8'h0 || os1 !== 8'h0 || ot1 !== 4'h0) begin
      errors++; $display("FAIL reset_outputs data=%h check=%h syn=%h tag=%h exp all 0", od1, oc1, os1, ot1); end
    checks++; if (cec1 !== 16'h0 || uec1 !== 16'h0) begin
      errors++; $display("FAIL reset_counters ce=%0d ue=%0d exp 0", cec1, uec1); end
    rst_n = 1'b1;
    #1;
    checks++; if (o_ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_ready1); end
  endtask

  task automatic test_generate();
    logic [31:0] vd [3];
    logic [7:0]  vc [3];
    vd[0] = 32'h00000001; vc[0] = 8'h51;
    vd[1] = 32'h80000000; vc[1] = 8'h8A;
    vd[2] = 32'h00000000; vc[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      beat1(1'b1, vd[k], 8'hFF, 4'(k + 1));
      checks++; if (o_valid1 !== 1'b0) begin errors++; $display("FAIL gen_latency_early[%0d] valid=%0b exp=0", k, o_valid1); end
      next();
      checks++; if (o_valid1 !== 1'b1) begin errors++; $display("FAIL gen_latency[%0d] valid=%0b exp=1", k, o_valid1); end
      checks++; if (oc1 !== vc[k]) begin errors++; $display("FAIL gen_check[%0d] got=%h exp=%h", k, oc1, vc[k]); end
      checks++; if (od1 !== vd[k]) begin errors++; $display("FAIL gen_data[%0d] got=%h exp=%h", k, od1, vd[k]); end
      checks++; if (os1 !== 8'h00 || oce1 !== 1'b0 || oue1 !== 1'b0) begin
        errors++; $display("FAIL gen_flags[%0d] syn=%h ce=%b ue=%b exp 0", k, os1, oce1, oue1); end
      checks++; if (ot1 !== 4'(k + 1)) begin errors++; $display("FAIL gen_tag[%0d] got=%0d exp=%0d", k, ot1, k + 1); end
      next();
      checks++; if (o_valid1 !== 1'b0) begin errors++; $display("FAIL gen_drain[%0d] valid=%0b exp=0", k, o_valid1); end
    end
    checks++; if (cec1 !== 16'h0 || uec1 !== 16'h0) begin
      errors++; $display("FAIL gen_counters ce=%0d ue=%0d exp 0", cec1, uec1); end
  endtask

  task automatic test_single_bit();
    beat1(1'b0, 32'h00000000, 8'h51, 4'd5);
    next();
    checks++; if (od1 !== 32'h00000001) begin errors++; $display("FAIL sbe_data got=%h exp=00000001", od1); end
    checks++; if (os1 !== 8'h51) begin errors++; $display("FAIL sbe_syn got=%h exp=51", os1); end
    checks++; if (oce1 !== 1'b1 || oue1 !== 1'b0) begin errors++; $display("FAIL sbe_flags ce=%b ue=%b exp ce=1 ue=0", oce1, oue1); end
    checks++; if (oc1 !== 8'h51) begin errors++; $display("FAIL sbe_check got=%h exp=51", oc1); end
    next();
    if (CNT_EN) exp_ce++;
    checks++; if (cec1 !== exp_ce || uec1 !== exp_ue) begin
      errors++; $display("FAIL sbe_counters ce=%0d ue=%0d exp ce=%0d ue=%0d", cec1, uec1, exp_ce, exp_ue); end
  endtask

  task automatic test_check_bit();
    beat1(1'b0, 32'h00000000, 8'h04, 4'd6);
    next();
    checks++; if (od1 !== 32'h0 || oc1 !== 8'h00) begin errors++; $display("FAIL cbe_data data=%h check=%h exp 0/00", od1, oc1); end
    checks++; if (os1 !== 8'h04) begin errors++; $display("FAIL cbe_syn got=%h exp=04", os1); end
    checks++; if (oce1 !== 1'b1 || oue1 !== 1'b0) begin errors++; $display("FAIL cbe_flags ce=%b ue=%b exp ce=1 ue=0", oce1, oue1); end
    next();
    if (CNT_EN) exp_ce++;
    checks++; if (cec1 !== exp_ce) begin errors++; $display("FAIL cbe_counter ce=%0d exp=%0d", cec1, exp_ce); end
  endtask

  task automatic test_double();
    checks++; if (uec1 !== 16'h0) begin errors++; $display("FAIL due_cnt_before got=%0d exp=0", uec1); end
    beat1(1'b0, 32'h80000001, 8'h00, 4'd7);
    next();
    checks++; if (os1 !== 8'hDB) begin errors++; $display("FAIL due_syn got=%h exp=DB", os1); end
    checks++; if (oue1 !== 1'b1 || oce1 !== 1'b0) begin errors++; $display("FAIL due_flags ce=%b ue=%b exp ce=0 ue=1", oce1, oue1); end
    checks++; if (od1 !== 32'h80000001 || oc1 !== 8'hDB) begin
      errors++; $display("FAIL due_data data=%h check=%h exp 80000001/DB", od1, oc1); end
    next();
    if (CNT_EN) exp_ue++;
    checks++; if (uec1 !== exp_ue || cec1 !== exp_ce) begin
      errors++; $display("FAIL due_counters ce=%0d ue=%0d exp ce=%0d ue=%0d", cec1, uec1, exp_ce, exp_ue); end
  endtask

  task automatic test_lanes2();
    logic [15:0] e;
    e = CNT_EN ? 16'd1 : 16'd0;
    rdy2 = 1'b1;
    v2 = 1'b1; we2 = 1'b0; d2 = {32'h80000001, 32'h00000000}; c2 = {8'h00, 8'h51}; t2 = 4'd3;
    next();
    v2 = 1'b0;
    next();
    checks++; if (o_valid2 !== 1'b1 || o_ready2 !== 1'b1) begin errors++; $display("FAIL l2_valid valid=%b ready=%b exp 1/1", o_valid2, o_ready2); end
    checks++; if (oce2 !== 2'b01 || oue2 !== 2'b10) begin errors++; $display("FAIL l2_flags ce=%b ue=%b exp 01/10", oce2, oue2); end
    checks++; if (od2 !== {32'h80000001, 32'h00000001}) begin errors++; $display("FAIL l2_data got=%h exp=8000000100000001", od2); end
    checks++; if (os2 !== 16'hDB51 || oc2 !== 16'hDB51) begin errors++; $display("FAIL l2_syn_check syn=%h check=%h exp DB51/DB51", os2, oc2); end
    checks++; if (ot2 !== 4'd3) begin errors++; $display("FAIL l2_tag got=%0d exp=3", ot2); end
    next();
    checks++; if (cec2 !== e || uec2 !== e) begin errors++; $display("FAIL l2_counters ce=%0d ue=%0d exp %0d/%0d", cec2, uec2, e, e); end
    // Clear held across the handshake of another erroneous beat.
    clr2 = 1'b1;
    v2 = 1'b1;
    next();
    v2 = 1'b0;
    next();
    next();
    checks++; if (cec2 !== 16'h0 || uec2 !== 16'h0) begin errors++; $display("FAIL l2_clr_priority ce=%0d ue=%0d exp 0/0", cec2, uec2); end
    clr2 = 1'b0;
    next();
    checks++; if (cec2 !== 16'h0 || uec2 !== 16'h0) begin errors++; $display("FAIL l2_clr_hold ce=%0d ue=%0d exp 0/0", cec2, uec2); end
  endtask

  task automatic test_backpressure();
    logic [31:0] bd [4];
    logic [7:0]  bc [4];
    logic [3:0]  bt [4];
    int sent, got;
    logic acc;
    bd[0] = 32'h00000001; bc[0] = 8'h51; bt[0] = 4'd1;
    bd[1] = 32'h80000000; bc[1] = 8'h8A; bt[1] = 4'd2;
    bd[2] = 32'h00000003; bc[2] = 8'h03; bt[2] = 4'd3;
    bd[3] = 32'h00000000; bc[3] = 8'h00; bt[3] = 4'd4;
    sent = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      rdy1 = (c >= 5);
      if (sent < 4) begin
        v1 = 1'b1; we1 = 1'b1; d1 = bd[sent]; c1 = 8'h00; t1 = bt[sent];
      end else begin
        v1 = 1'b0;
      end
      #1;
      if (c >= 2 && c <= 4) begin
        checks++; if (o_valid1 !== 1'b1 || o_ready1 !== 1'b0) begin
          errors++; $display("FAIL bp_stall[%0d] valid=%b ready=%b exp 1/0", c, o_valid1, o_ready1); end
        checks++; if (od1 !== bd[0] || ot1 !== bt[0] || oc1 !== bc[0]) begin
          errors++; $display("FAIL bp_stable[%0d] data=%h tag=%0d check=%h exp %h/%0d/%h", c, od1, ot1, oc1, bd[0], bt[0], bc[0]); end
      end
      acc = v1 & o_ready1;
      if (o_valid1 && rdy1) begin
        if (got < 4) begin
          checks++; if (od1 !== bd[got] || ot1 !== bt[got] || oc1 !== bc[got]) begin
            errors++; $display("FAIL bp_order[%0d] data=%h tag=%0d check=%h exp %h/%0d/%h", got, od1, ot1, oc1, bd[got], bt[got], bc[got]); end
        end else begin
          errors++; $display("FAIL bp_extra_beat tag=%0d exp none", ot1);
        end
        got++;
      end
      next();
      if (acc) sent++;
      if (c == 4) begin
        checks++; if (sent !== 2) begin errors++; $display("FAIL bp_held accepted=%0d exp=2", sent); end
      end
      if (sent == 4 && got == 4) break;
    end
    v1 = 1'b0;
    rdy1 = 1'b1;
    checks++; if (got !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", got); end
  endtask

  task automatic test_reset_midstream();
    rdy1 = 1'b1;
    v1 = 1'b1; we1 = 1'b1; d1 = 32'h00000001; c1 = 8'h00; t1 = 4'd9;
    next();
    d1 = 32'h00000003; t1 = 4'd10;
    next();
    v1 = 1'b0;
    checks++; if (o_valid1 !== 1'b1 || ot1 !== 4'd9) begin errors++; $display("FAIL rst_pre valid=%b tag=%0d exp 1/9", o_valid1, ot1); end
    rst_n = 1'b0;
    next();
    checks++; if (o_valid1 !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", o_valid1); end
    checks++; if (od1 !== 32'h0 || ot1 !== 4'h0 || oc1 !== 8'h0) begin
      errors++; $display("FAIL rst_mid_outputs data=%h tag=%0d check=%h exp 0", od1, ot1, oc1); end
    checks++; if (cec1 !== 16'h0 || uec1 !== 16'h0) begin errors++; $display("FAIL rst_mid_counters ce=%0d ue=%0d exp 0", cec1, uec1); end
    exp_ce = '0; exp_ue = '0;
    rst_n = 1'b1;
    #1;
    checks++; if (o_ready1 !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", o_ready1); end
    next();
    checks++; if (o_valid1 !== 1'b0) begin errors++; $display("FAIL rst_discard valid=%b exp=0", o_valid1); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; we1 = 1'b0; d1 = '0; c1 = '0; t1 = '0; rdy1 = 1'b1; clr1 = 1'b0;
    v2 = 1'b0; we2 = 1'b0; d2 = '0; c2 = '0; t2 = '0; rdy2 = 1'b1; clr2 = 1'b0;
    #1;
    test_reset();
    test_generate();
    test_single_bit();
    test_check_bit();
    test_double();
    test_lanes2();
    test_backpressure();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
